// File: rtl/stream_pkg.sv
// Shared sizing helpers for the stream receive path.
package stream_pkg;

    // Pointer width for a circular buffer of 'depth' entries; never narrower than 1 bit.
    function automatic int ptr_w(int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Width needed to hold an occupancy from 0 up to and including 'depth'.
    function automatic int count_w(int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_rx_fifo_mem.sv
// Register-array storage for the receive FIFO: one synchronous write port,
// one asynchronous read port, no reset (contents are masked at the top level).
module stream_rx_fifo_mem
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [ptr_w(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [ptr_w(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]        rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Capture the incoming word into the addressed slot when a push is accepted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_rx_fifo.sv
// First-word-fall-through receive FIFO for the non-stallable shift pipeline.
// Absorbs push-only input, re-presents it over valid/ready, drops and flags
// any word that arrives while full with no simultaneous pop.
module stream_rx_fifo
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          i_data,
    input  logic                      i_valid,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [count_w(DEPTH)-1:0] o_count,
    output logic                      o_full,
    output logic                      o_overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = count_w(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head_data;
    logic             pop;
    logic             push_ok;
    logic             drop;

    // Explicit wrap keeps pointers inside the array for non-power-of-two depths.
    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign o_valid = (o_count != '0);
    assign o_full  = (o_count == FULL_CNT);
    assign pop     = o_valid && i_ready;
    assign push_ok = i_valid && (!o_full || pop);
    assign drop    = i_valid && o_full && !pop;
    assign o_data  = o_valid ? head_data : '0;

    stream_rx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    // Advance pointers and occupancy on accepted pushes/pops; latch any dropped push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= inc_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= inc_ptr(rd_ptr);
            end
            case ({push_ok, pop})
                2'b10:   o_count <= o_count + CW'(1);
                2'b01:   o_count <= o_count - CW'(1);
                default: o_count <= o_count;
            endcase
            if (drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifndef __ICARUS__
    a_count_range: assert property (@(posedge clk) disable iff (rst) o_count <= FULL_CNT);
    a_full_valid:  assert property (@(posedge clk) disable iff (rst) o_full |-> o_valid);
    a_ovf_cause:   assert property (@(posedge clk) disable iff (rst) $rose(o_overflow) |-> $past(drop));
`endif

endmodule

// File: tb/tb_stream_rx_fifo.sv
// Directed bench for stream_rx_fifo: a DEPTH=4 instance for fill/drain,
// overflow, pass-through and reset, and a DEPTH=3 instance for wrap-around.
module tb_stream_rx_fifo;

    logic       clk;
    logic       rst;

    logic [7:0] a_idata;
    logic       a_ivalid;
    logic       a_iready;
    logic [7:0] a_odata;
    logic       a_ovalid;
    logic [2:0] a_count;
    logic       a_full;
    logic       a_ovf;

    logic [7:0] b_idata;
    logic       b_ivalid;
    logic       b_iready;
    logic [7:0] b_odata;
    logic       b_ovalid;
    logic [1:0] b_count;
    logic       b_full;
    logic       b_ovf;

    int         check_count;
    int         pass_count;

    logic [7:0] sb [$];
    int         m_count;
    int         sent;
    int         received;
    logic       m_pop;
    logic       m_push;

    stream_rx_fifo #(.WIDTH(8), .DEPTH(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_data     (a_idata),
        .i_valid    (a_ivalid),
        .o_data     (a_odata),
        .o_valid    (a_ovalid),
        .i_ready    (a_iready),
        .o_count    (a_count),
        .o_full     (a_full),
        .o_overflow (a_ovf)
    );

    stream_rx_fifo #(.WIDTH(8), .DEPTH(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_data     (b_idata),
        .i_valid    (b_ivalid),
        .o_data     (b_odata),
        .o_valid    (b_ovalid),
        .i_ready    (b_iready),
        .o_count    (b_count),
        .o_full     (b_full),
        .o_overflow (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: counts it, and reports tag/got/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        assert (got === exp) pass_count++;
        else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Full output snapshot of the DEPTH=4 instance.
    task automatic checkA(input string tag, input logic [31:0] v, input logic [31:0] d,
                          input logic [31:0] c, input logic [31:0] f, input logic [31:0] o);
        checkOutput({tag, ".valid"}, 32'(a_ovalid), v);
        checkOutput({tag, ".data"},  32'(a_odata),  d);
        checkOutput({tag, ".count"}, 32'(a_count),  c);
        checkOutput({tag, ".full"},  32'(a_full),   f);
        checkOutput({tag, ".ovf"},   32'(a_ovf),    o);
    endtask

    // Drive the DEPTH=4 instance's inputs for the next edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
        a_ivalid = v;
        a_idata  = d;
        a_iready = r;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges so no push/pop can be in flight.
    task automatic pulseReset();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst      = 1'b1;
        b_idata  = 8'h00;
        b_ivalid = 1'b0;
        b_iready = 1'b0;
        applyStimulus(1'b1, 8'hAA, 1'b0);

        // Reset held with a push presented: everything stays cleared.
        tick();
        checkA("t1.rst0", 0, 0, 0, 0, 0);
        tick();
        checkA("t1.rst1", 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 8'hAA, 1'b0);
        rst = 1'b0;
        tick();
        checkA("t1.rel", 0, 0, 0, 0, 0);

        // Fill to DEPTH with no reader, then drain in order.
        applyStimulus(1'b1, 8'h01, 1'b0); tick(); checkA("t2.p1", 1, 'h01, 1, 0, 0);
        applyStimulus(1'b1, 8'h02, 1'b0); tick(); checkA("t2.p2", 1, 'h01, 2, 0, 0);
        applyStimulus(1'b1, 8'h03, 1'b0); tick(); checkA("t2.p3", 1, 'h01, 3, 0, 0);
        applyStimulus(1'b1, 8'h04, 1'b0); tick(); checkA("t2.p4", 1, 'h01, 4, 1, 0);
        applyStimulus(1'b0, 8'h00, 1'b1); tick(); checkA("t2.d1", 1, 'h02, 3, 0, 0);
        tick(); checkA("t2.d2", 1, 'h03, 2, 0, 0);
        tick(); checkA("t2.d3", 1, 'h04, 1, 0, 0);
        tick(); checkA("t2.d4", 0, 'h00, 0, 0, 0);

        // Push while full with no pop: word dropped, sticky flag set.
        applyStimulus(1'b1, 8'h01, 1'b0); tick();
        applyStimulus(1'b1, 8'h02, 1'b0); tick();
        applyStimulus(1'b1, 8'h03, 1'b0); tick();
        applyStimulus(1'b1, 8'h04, 1'b0); tick(); checkA("t3.full", 1, 'h01, 4, 1, 0);
        applyStimulus(1'b1, 8'h05, 1'b0); tick(); checkA("t3.drop", 1, 'h01, 4, 1, 1);
        applyStimulus(1'b0, 8'h00, 1'b1); tick(); checkA("t3.d1", 1, 'h02, 3, 0, 1);
        tick(); checkA("t3.d2", 1, 'h03, 2, 0, 1);
        tick(); checkA("t3.d3", 1, 'h04, 1, 0, 1);
        tick(); checkA("t3.d4", 0, 'h00, 0, 0, 1);
        tick(); checkA("t3.hold", 0, 'h00, 0, 0, 1);

        // Mid-cycle reset clears the sticky flag without an edge.
        applyStimulus(1'b0, 8'h00, 1'b0);
        pulseReset();
        checkA("t4.rst", 0, 'h00, 0, 0, 0);

        // Full with simultaneous push and pop: both succeed, no overflow.
        applyStimulus(1'b1, 8'h01, 1'b0); tick();
        applyStimulus(1'b1, 8'h02, 1'b0); tick();
        applyStimulus(1'b1, 8'h03, 1'b0); tick();
        applyStimulus(1'b1, 8'h04, 1'b0); tick(); checkA("t4.full", 1, 'h01, 4, 1, 0);
        applyStimulus(1'b1, 8'h05, 1'b1); tick(); checkA("t4.s5", 1, 'h02, 4, 1, 0);
        applyStimulus(1'b1, 8'h06, 1'b1); tick(); checkA("t4.s6", 1, 'h03, 4, 1, 0);
        applyStimulus(1'b1, 8'h07, 1'b1); tick(); checkA("t4.s7", 1, 'h04, 4, 1, 0);
        applyStimulus(1'b0, 8'h00, 1'b1); tick(); checkA("t4.d5", 1, 'h05, 3, 0, 0);
        tick(); checkA("t4.d6", 1, 'h06, 2, 0, 0);
        tick(); checkA("t4.d7", 1, 'h07, 1, 0, 0);
        tick(); checkA("t4.end", 0, 'h00, 0, 0, 0);

        // Reset mid-operation with two words buffered, then a fresh push.
        applyStimulus(1'b1, 8'h5A, 1'b0); tick();
        applyStimulus(1'b1, 8'h5B, 1'b0); tick(); checkA("t6.pre", 1, 'h5A, 2, 0, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        #1 rst = 1'b1;
        #1;
        checkA("t6.async", 0, 'h00, 0, 0, 0);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 8'h5A, 1'b0); tick(); checkA("t6.push", 1, 'h5A, 1, 0, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        // DEPTH=3 wrap-around: 20 words, random valid/ready, in-order scoreboard.
        m_count  = 0;
        sent     = 0;
        received = 0;
        for (int cyc = 0; cyc < 400 && !(sent == 20 && m_count == 0); cyc++) begin
            b_iready = 1'($urandom_range(0, 1));
            m_pop    = (m_count != 0) && b_iready;
            checkOutput("t5.valid", 32'(b_ovalid), 32'(m_count != 0));
            checkOutput("t5.count", 32'(b_count), 32'(m_count));
            if (m_pop) begin
                checkOutput("t5.data", 32'(b_odata), 32'(sb[0]));
                void'(sb.pop_front());
                received++;
            end
            m_push   = (sent < 20) && ($urandom_range(0, 3) != 0) && (m_count < 3 || m_pop);
            b_ivalid = m_push;
            b_idata  = 8'(8'h40 + sent);
            if (m_push) begin
                sb.push_back(b_idata);
                sent++;
            end
            m_count = m_count + int'(m_push) - int'(m_pop);
            tick();
        end
        b_ivalid = 1'b0;
        b_iready = 1'b0;
        checkOutput("t5.received", 32'(received), 32'd20);
        checkOutput("t5.ovf", 32'(b_ovf), 32'd0);
        checkOutput("t5.empty", 32'(b_ovalid), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/stream_rx_fifo.md
# stream_rx_fifo

Receive-side buffer for the fixed-latency shift pipeline's `o_data`/`o_valid` stream. The pipeline cannot stall, so this block absorbs its push-only output into a circular first-word-fall-through FIFO. It re-presents the data to downstream logic over a valid/ready handshake. Overflow is detected, the offending word is dropped, and a sticky flag records the event.

## Interface
- `WIDTH`, default 8: data word width in bits.
- `DEPTH`, default 4: FIFO capacity in words, minimum 2; non-power-of-two values are legal.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_data`  in  WIDTH  word from the upstream pipeline.
- `i_valid`  in  1  `i_data` is a word to push. There is no backpressure path upstream.
- `o_data`  out  WIDTH  head word; forced to 0 while `o_valid` is 0.
- `o_valid`  out  1  FIFO non-empty.
- `i_ready`  in  1  downstream accepts the head word this cycle.
- `o_count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- `o_full`  out  1  `o_count == DEPTH`.
- `o_overflow`  out  1  sticky; a push was dropped since reset.

## Operation
- **Storage:** DEPTH-entry register array, with write pointer `wr_ptr` and read pointer `rd_ptr`.
  - Both pointers are $clog2(DEPTH) bits, minimum 1.
  - Increment rule: the value `DEPTH-1` wraps explicitly to 0. Pointers never reach `DEPTH`.
- **Handshake terms:**
  - pop = `o_valid && i_ready`.
  - push_ok = `i_valid && (!o_full || pop)`.
- **On push_ok:** write `mem[wr_ptr] <= i_data`, then advance `wr_ptr`.
- **On pop:** advance `rd_ptr`.
- **Count update:** `o_count` += push_ok, −= pop. A simultaneous push and pop leaves it unchanged.
- **Drop:** `i_valid && o_full && !pop` drops the word.
  - Pointers, count and memory are unchanged.
  - `o_overflow` is set to 1 and held until `rst`.
- **Full with simultaneous push and pop:** both succeed; the count stays at DEPTH and no overflow occurs.
- **Empty:** pop cannot occur because `o_valid` is 0. A push goes to count 1. `i_ready` is ignored.
- **Outputs:**
  - `o_valid` = (`o_count != 0`).
  - `o_data` = `o_valid ? mem[rd_ptr] : '0`.
- **No FSM:** behaviour is fully determined by the occupancy counter. The two boundary states are count 0 (empty) and count DEPTH (full).
- **Reset:**
  - `rst` = 1 asynchronously clears `wr_ptr`, `rd_ptr`, `o_count` and `o_overflow`.
  - The outputs are then `o_valid`=0, `o_data`=0, `o_full`=0, `o_count`=0 and `o_overflow`=0.
  - Memory contents are not reset and are never observable, because `o_data` is masked.
  - Reset mid-operation discards all buffered words. A push presented in the release cycle is accepted normally on the first rising edge after `rst` falls.

## Timing
- **Push-to-visible latency:** 1 cycle. A word pushed at edge N appears on `o_data` with `o_valid`=1 after edge N, i.e. in cycle N+1.
- **Pop:** takes effect at the edge where pop is true. The next word, or `o_valid`=0, is visible in the following cycle.
- **Combinational paths:**
  - From `i_ready`: only into the push_ok decision for the full case.
  - From `i_valid`/`i_data` to any output: none.
- **Throughput:** one push and one pop per cycle, sustained.

## Structure
- **Shared package `stream_pkg`:**
  - `function automatic int ptr_w(int depth)`, returning max(1, $clog2(depth)).
  - A `count_w` helper, returning $clog2(depth+1).
- **Sub-module `stream_rx_fifo_mem`:**
  - Parameterised WIDTH/DEPTH register array with one write port and one asynchronous read port.
  - Has no reset.
  - The top level holds the pointers, counter, flags and output masking.
- **Assertions:** guarded by `ifndef __ICARUS__`:
  - `o_count <= DEPTH`;
  - `o_full |-> o_valid`;
  - `$rose(o_overflow)` only when `i_valid && o_full && !pop`.

## Test plan
1. **Reset values:** assert `rst` with `i_valid`=1 and `i_data`=8'hAA. Require all outputs at 0 throughout. After release with `i_valid`=0, outputs stay at 0.
2. **Fill and drain:** DEPTH=4, `i_ready`=0, push 01,02,03,04.
   - Required: `o_full`=1 and `o_count`=4. `o_data`=01 from the cycle after the first push.
   - Then `i_ready`=1: `o_data` goes 01,02,03,04, then `o_valid`=0 and `o_data`=0.
3. **Overflow:** with the FIFO full (01..04), push 05 with `i_ready`=0.
   - Required: `o_overflow`=1 and `o_count`=4. The drained sequence is 01..04; 05 is absent.
   - `o_overflow` stays 1 until `rst`.
4. **Full pass-through:** with the FIFO full, hold `i_ready`=1 and stream 05,06,07.
   - Required: `o_count` stays 4, `o_overflow` stays 0, and the output order is 01,02,03,04,05,06,07.
5. **Wrap-around, DEPTH=3:** stream 20 words at random `i_ready` duty. Require in-order output with no loss while the occupancy stays ≤3, including pointer wrap past index 2.
6. **Reset mid-operation:** with `o_count`=2, assert `rst` for 1 cycle between edges.
   - Required: outputs clear immediately, without waiting for an edge.
   - A subsequent push of 0x5A yields `o_data`=5A and `o_count`=1 one cycle later.
